// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and defaults for the scratch-memory arbiter: FSM states, requester ids,
// default geometry/wait constants and the wait-counter width helper.
package mem_access_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        ACK   = 3'd4,
        TURN  = 3'd5
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_DATA_W     = 4;
    localparam int DEF_READ_WAIT  = 16;
    localparam int DEF_WRITE_WAIT = 9;

    // Counter must hold max(wait)-1; a 1-cycle wait still needs a 1-bit register.
    function automatic int cnt_width(input int rw, input int ww);
        int m;
        m = (rw > ww) ? rw : ww;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/memctrl_wait_timer.sv
// Loadable down-counter that stops at zero; done is high whenever the count is zero.
module memctrl_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin two-client sequencer for the asynchronous 16x4 scratch memory.
// Define MEMCTRL_TURNAROUND_EN to insert a 1-cycle TURN idle state after every ACK.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_WAIT = DEF_WRITE_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    localparam int CNT_W = cnt_width(READ_WAIT, WRITE_WAIT);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WAIT - 1);

    state_t            state;
    req_id_t           last_grant;
    req_id_t           owner;
    req_id_t           winner;
    logic              op_we;
    logic [DATA_W-1:0] wdata_q;
    logic              tmr_load;
    logic              tmr_done;
    logic [CNT_W-1:0]  tmr_val;

    // The bus is tied to mem_wr so the controller can never drive while WR is high.
    assign mem_data = mem_wr ? {DATA_W{1'bz}} : wdata_q;

    assign tmr_load = (state == SETUP);
    assign tmr_val  = op_we ? WRITE_LOAD : READ_LOAD;

    memctrl_wait_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // On a tie the client that did not win last time is served.
    always_comb begin
        winner = REQ_A;
        if (req_a && req_b) begin
            winner = (last_grant == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            winner = REQ_B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_wr     <= 1'b1;
            mem_addr   <= '0;
            rdata      <= '0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            busy       <= 1'b0;
            last_grant <= REQ_B;
            owner      <= REQ_A;
            op_we      <= 1'b0;
            wdata_q    <= '0;
        end else begin
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_a || req_b) begin
                        owner      <= winner;
                        last_grant <= winner;
                        if (winner == REQ_B) begin
                            op_we    <= we_b;
                            mem_addr <= addr_b;
                            wdata_q  <= wdata_b;
                        end else begin
                            op_we    <= we_a;
                            mem_addr <= addr_a;
                            wdata_q  <= wdata_a;
                        end
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (op_we) begin
                        mem_wr <= 1'b0;
                        state  <= WRITE;
                    end else begin
                        state  <= READ;
                    end
                end
                WRITE: begin
                    if (tmr_done) begin
                        mem_wr <= 1'b1;
                        ack_a  <= (owner == REQ_A);
                        ack_b  <= (owner == REQ_B);
                        state  <= ACK;
                    end
                end
                READ: begin
                    if (tmr_done) begin
                        rdata <= mem_data;
                        ack_a <= (owner == REQ_A);
                        ack_b <= (owner == REQ_B);
                        state <= ACK;
                    end
                end
                ACK: begin
`ifdef MEMCTRL_TURNAROUND_EN
                    state <= TURN;
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
                TURN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: default-timing instance plus a READ_WAIT=WRITE_WAIT=1 instance,
// each with a simple behavioural memory on its bus.
module tb_mem_access_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       req_a, req_b, we_a, we_b;
    logic [3:0] addr_a, addr_b, wdata_a, wdata_b;
    logic       ack_a, ack_b, busy, mem_wr;
    logic [3:0] rdata, mem_addr;
    wire  [3:0] mem_data;

    logic       f_req_a, f_req_b, f_we_a, f_we_b;
    logic [3:0] f_addr_a, f_addr_b, f_wdata_a, f_wdata_b;
    logic       f_ack_a, f_ack_b, f_busy, f_mem_wr;
    logic [3:0] f_rdata, f_mem_addr;
    wire  [3:0] f_mem_data;

    logic [3:0] mem_q   [16];
    logic [3:0] f_mem_q [16];

    mem_access_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata(rdata), .busy(busy),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    mem_access_arbiter #(.READ_WAIT(1), .WRITE_WAIT(1)) u_fast (
        .clk(clk), .reset(reset),
        .req_a(f_req_a), .req_b(f_req_b), .we_a(f_we_a), .we_b(f_we_b),
        .addr_a(f_addr_a), .addr_b(f_addr_b), .wdata_a(f_wdata_a), .wdata_b(f_wdata_b),
        .ack_a(f_ack_a), .ack_b(f_ack_b), .rdata(f_rdata), .busy(f_busy),
        .mem_wr(f_mem_wr), .mem_addr(f_mem_addr), .mem_data(f_mem_data)
    );

    // Memory models: drive stored data while WR is high, capture the bus while WR is low.
    assign mem_data   = mem_wr   ? mem_q[mem_addr]     : 4'bz;
    assign f_mem_data = f_mem_wr ? f_mem_q[f_mem_addr] : 4'bz;

    always @(negedge clk) begin
        if (!mem_wr)   mem_q[mem_addr]     = mem_data;
        if (!f_mem_wr) f_mem_q[f_mem_addr] = f_mem_data;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Bus monitor on the default instance.
    logic [3:0] exp_wdata = 4'h0;
    logic [3:0] prev_addr = 4'h0;
    logic       prev_low = 1'b0;
    int         low_cnt = 0;
    int         last_low = 0;

    always @(negedge clk) begin
        if (!mem_wr) begin
            chk("bus_wdata", int'(mem_data), int'(exp_wdata));
            if (prev_low) chk("addr_stable_in_write", int'(mem_addr), int'(prev_addr));
            low_cnt++;
        end else begin
            chk("bus_no_contention", int'(mem_data), int'(mem_q[mem_addr]));
            if (prev_low) last_low = low_cnt;
            low_cnt = 0;
        end
        prev_low  = !mem_wr;
        prev_addr = mem_addr;
    end

    task automatic do_access(input bit fast, input bit cl, input bit we, input logic [3:0] addr,
                             input logic [3:0] wdata, output int cyc, output bit got_a, output bit got_b);
        int n;
        cyc = -1; got_a = 1'b0; got_b = 1'b0;
        @(negedge clk);
        n = 0;
        while ((fast ? f_busy : busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!fast) exp_wdata = wdata;
        if (fast) begin
            if (cl) begin f_req_b = 1'b1; f_we_b = we; f_addr_b = addr; f_wdata_b = wdata; end
            else    begin f_req_a = 1'b1; f_we_a = we; f_addr_a = addr; f_wdata_a = wdata; end
        end else begin
            if (cl) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; end
            else    begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; end
        end
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (fast ? (f_ack_a || f_ack_b) : (ack_a || ack_b)) begin
                cyc   = k + 1;
                got_a = fast ? f_ack_a : ack_a;
                got_b = fast ? f_ack_b : ack_b;
                break;
            end
        end
        if (fast) begin f_req_a = 1'b0; f_req_b = 1'b0; end
        else      begin req_a = 1'b0;   req_b = 1'b0;   end
    endtask

    typedef struct {
        bit         fast;
        bit         cl;
        bit         we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rdata;
        int         exp_cyc;
    } vec_t;

    localparam int NV = 10;
`ifdef MEMCTRL_TURNAROUND_EN
    localparam int HELD_SPACING = 20;
`else
    localparam int HELD_SPACING = 19;
`endif

    vec_t vec [NV];
    int   cyc;
    bit   got_a, got_b;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{1'b0, 1'b0, 1'b1, 4'h3, 4'hA, 4'h0, 11};
        vec[1] = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'hA, 18};
        vec[2] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'hF, 4'hA, 11};
        vec[3] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 18};
        vec[4] = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'hA, 18};
        vec[5] = '{1'b0, 1'b1, 1'b1, 4'h3, 4'h5, 4'hA, 11};
        vec[6] = '{1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h5, 18};
        vec[7] = '{1'b1, 1'b0, 1'b1, 4'h5, 4'h6, 4'h0, 3};
        vec[8] = '{1'b1, 1'b1, 1'b0, 4'h5, 4'h0, 4'h6, 3};
        vec[9] = '{1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'h6, 3};

        for (int i = 0; i < 16; i++) begin
            mem_q[i]   = 4'h0;
            f_mem_q[i] = 4'h0;
        end
        mem_q[1] = 4'h5;
        mem_q[2] = 4'hC;
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        f_req_a = 0; f_req_b = 0; f_we_a = 0; f_we_b = 0;
        f_addr_a = 0; f_addr_b = 0; f_wdata_a = 0; f_wdata_b = 0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_wr", int'(mem_wr), 1);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_rdata", int'(rdata), 0);
        chk("rst_acks", int'({ack_a, ack_b}), 0);
        chk("rst_fast_mem_wr", int'(f_mem_wr), 1);

        // Table of single-client accesses on both instances
        for (int i = 0; i < NV; i++) begin
            do_access(vec[i].fast, vec[i].cl, vec[i].we, vec[i].addr, vec[i].wdata, cyc, got_a, got_b);
            chk($sformatf("v%0d_ack_cycle", i), cyc, vec[i].exp_cyc);
            chk($sformatf("v%0d_ack_id", i), int'({got_a, got_b}), vec[i].cl ? 1 : 2);
            chk($sformatf("v%0d_rdata", i), int'(vec[i].fast ? f_rdata : rdata), int'(vec[i].exp_rdata));
            if (!vec[i].fast && vec[i].we) begin
                @(negedge clk);
                chk($sformatf("v%0d_wr_low_cycles", i), last_low, 9);
            end
        end

        // Both clients requesting from reset: strict alternation A, B, A, B
        reset = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 4'h1;
        req_b = 1'b1; we_b = 1'b0; addr_b = 4'h2;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            int got;
            int exp_id;
            exp_id = j % 2;
            got = -1;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (ack_a || ack_b) begin
                    got = ack_b ? 1 : 0;
                    break;
                end
            end
            chk($sformatf("alt%0d_winner", j), got, exp_id);
            chk($sformatf("alt%0d_rdata", j), int'(rdata), exp_id == 1 ? 12 : 5);
            if (got == 1) req_b = 1'b0;
            else          req_a = 1'b0;
            @(negedge clk);
            if (j < 2) begin
                if (got == 1) req_b = 1'b1;
                else          req_a = 1'b1;
            end
        end
        req_a = 1'b0; req_b = 1'b0;

        // Held req_b: three back-to-back reads
        begin
            int t, acks, t_prev;
            @(negedge clk);
            while (busy) @(negedge clk);
            req_b = 1'b1; we_b = 1'b0; addr_b = 4'h2;
            t = 0; acks = 0; t_prev = 0;
            while (acks < 3 && t < 200) begin
                @(negedge clk);
                t++;
                if (ack_b) begin
                    if (acks > 0) chk($sformatf("held_spacing%0d", acks), t - t_prev, HELD_SPACING);
                    t_prev = t;
                    acks++;
                    if (acks == 3) req_b = 1'b0;
                end
            end
            req_b = 1'b0;
            chk("held_ack_count", acks, 3);
        end

        // Reset during the 4th WRITE cycle
        @(negedge clk);
        while (busy) @(negedge clk);
        exp_wdata = 4'h9;
        req_a = 1'b1; we_a = 1'b1; addr_a = 4'h7; wdata_a = 4'h9;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("mw_in_write", int'(mem_wr), 0);
        reset = 1'b1;
        req_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mw_mem_wr", int'(mem_wr), 1);
        chk("mw_busy", int'(busy), 0);
        chk("mw_no_ack", int'({ack_a, ack_b}), 0);
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (ack_a || ack_b || busy) seen++;
            end
            chk("mw_quiet_after_reset", seen, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
